// File: rtl/seq_pkg.sv
// seq_pkg: shared state encoding, branch codes and address-select values for instr_sequencer.
// The FAULT state exists only when SEQ_MEM_TIMEOUT_EN is defined.
package seq_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
`ifdef SEQ_MEM_TIMEOUT_EN
    , S_FAULT
`endif
  } state_t;
  localparam logic [2:0] BR_EQ     = 3'b000;
  localparam logic [2:0] BR_NE     = 3'b001;
  localparam logic [2:0] BR_NONE   = 3'b010;
  localparam logic [2:0] BR_ALWAYS = 3'b011;
  localparam logic ADDR_PC  = 1'b0;
  localparam logic ADDR_ALU = 1'b1;
endpackage

// File: rtl/seq_timeout.sv
// seq_timeout: counts consecutive memory wait cycles and flags expiry on the MEM_TIMEOUT-th one.
// Built only with SEQ_MEM_TIMEOUT_EN.
`ifdef SEQ_MEM_TIMEOUT_EN
module seq_timeout #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_wait,
  input  logic i_done,
  output logic o_expired
);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  logic [CW-1:0] r_count;
  assign o_expired = i_wait & (r_count == CW'(MEM_TIMEOUT - 1));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_count <= '0;
    else if (i_done) r_count <= '0;
    else if (i_wait) r_count <= r_count + CW'(1);
  end
endmodule
`endif

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle fetch/decode/exec/mem/wb sequencer with shared-memory handshake.
// Define SEQ_MEM_TIMEOUT_EN to add a sticky memory-wait timeout (FAULT state).
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int RETIRE_W    = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_run,
  input  logic                i_mem_ready,
  input  logic                i_data_read_en,
  input  logic                i_data_write_en,
  input  logic                i_reg_write_en,
  input  logic [2:0]          i_branch_cond,
  input  logic                i_regs_equal,
  output logic                o_mem_req,
  output logic                o_mem_we,
  output logic                o_addr_sel,
  output logic                o_ir_load,
  output logic                o_pc_load,
  output logic                o_pc_branch,
  output logic                o_reg_we,
  output logic                o_busy,
  output logic                o_fault,
  output logic [RETIRE_W-1:0] o_retired_count
);
  state_t r_state, w_next;
  logic [RETIRE_W-1:0] r_retired;
  logic w_taken, w_retire, w_done;
  assign w_done  = o_mem_req & i_mem_ready;
  assign w_taken = (i_branch_cond == BR_EQ & i_regs_equal) | (i_branch_cond == BR_NE & !i_regs_equal) |
                   (i_branch_cond == BR_ALWAYS);
  // Retire points: no-write op in EXEC, completed store in MEM, every WB.
  assign w_retire = (r_state == S_EXEC & !i_data_write_en & !i_data_read_en & !i_reg_write_en) |
                    (r_state == S_MEM & w_done & i_data_write_en) | (r_state == S_WB);
  assign o_mem_req       = (r_state == S_FETCH) | (r_state == S_MEM);
  assign o_mem_we        = (r_state == S_MEM) & i_data_write_en;
  assign o_addr_sel      = (r_state == S_MEM) ? ADDR_ALU : ADDR_PC;
  assign o_ir_load       = (r_state == S_FETCH) & i_mem_ready;
  assign o_pc_load       = w_retire;
  assign o_pc_branch     = w_retire & w_taken;
  assign o_reg_we        = r_state == S_WB;
  assign o_busy          = r_state != S_IDLE;
  assign o_retired_count = r_retired;
`ifdef SEQ_MEM_TIMEOUT_EN
  logic w_expired;
  seq_timeout #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_wait   (o_mem_req & !i_mem_ready),
    .i_done   (w_done),
    .o_expired(w_expired)
  );
  assign o_fault = r_state == S_FAULT;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = MEM_TIMEOUT[0];
  assign o_fault = 1'b0;
`endif
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = i_run ? S_FETCH : S_IDLE;
      S_FETCH:  w_next = i_mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: w_next = S_EXEC;
      S_EXEC:   w_next = (i_data_write_en | i_data_read_en) ? S_MEM : S_WB;
      S_MEM:    w_next = i_mem_ready ? S_WB : S_MEM;
      default:  w_next = r_state;
    endcase
    if (w_retire) w_next = i_run ? S_FETCH : S_IDLE;
`ifdef SEQ_MEM_TIMEOUT_EN
    if (w_expired) w_next = S_FAULT;
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_retired <= r_retired + RETIRE_W'(1);
    end
  end
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed instruction stream checked every cycle against a phase-level model.
module tb_instr_sequencer;
  logic clk = 0, rst_n = 0, run = 0, mem_ready = 0, rd = 0, wr = 0, rw = 0, eq = 0;
  logic [2:0] bc = 3'b010;
  logic mem_req, mem_we, addr_sel, ir_load, pc_load, pc_branch, reg_we, busy, fault;
  logic [3:0] retired_count;
  logic n_rst = 0, n_run = 0, n_rdy = 0, n_rd = 0, n_wr = 0, n_rw = 0, n_eq = 0;
  logic [2:0] n_bc = 3'b010;
  logic [12:0] exp_v = '0, w_act;
  string exp_tag = "";
  bit chk_en = 0;
  int checks = 0, errors = 0, m_count = 0;
  int g_n, g_seen, g_start;
  logic g_br, s_count_fault;
  logic [3:0] s_count;

  always #5 clk = ~clk;

  instr_sequencer #(.RETIRE_W(4), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .i_run(run), .i_mem_ready(mem_ready),
    .i_data_read_en(rd), .i_data_write_en(wr), .i_reg_write_en(rw),
    .i_branch_cond(bc), .i_regs_equal(eq),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_addr_sel(addr_sel), .o_ir_load(ir_load),
    .o_pc_load(pc_load), .o_pc_branch(pc_branch), .o_reg_we(reg_we), .o_busy(busy),
    .o_fault(fault), .o_retired_count(retired_count)
  );

  assign w_act = {mem_req, mem_we, addr_sel, ir_load, pc_load, pc_branch, reg_we, busy, fault, retired_count};

  always @(negedge clk) if (chk_en) begin
    checks++;
    if (w_act !== exp_v) begin
      errors++;
      $display("FAIL %s: got req,we,as,ir,pcl,pcb,rwe,busy,flt,cnt=%b expected %b", exp_tag, w_act, exp_v);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [12:0] ev(bit req, bit we, bit as, bit irl, bit pcl, bit pcb, bit rwe, bit bsy, bit flt);
    return {req, we, as, irl, pcl, pcb, rwe, bsy, flt, 4'(m_count)};
  endfunction

  function automatic bit taken(logic [2:0] c, logic e);
    return (c == 3'b000 && e) || (c == 3'b001 && !e) || c == 3'b011;
  endfunction

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  task automatic cyc(input string tag, input logic [12:0] e);
    @(posedge clk); #1;
    rst_n = n_rst; run = n_run; mem_ready = n_rdy;
    rd = n_rd; wr = n_wr; rw = n_rw; bc = n_bc; eq = n_eq;
    exp_v = e; exp_tag = tag; chk_en = 1;
    @(negedge clk);
    s_count = retired_count;
    s_count_fault = fault;
    g_n++;
    if (pc_load && g_seen < 0) begin g_seen = g_n; g_br = pc_branch; end
  endtask

  // kind: 0 no-write, 1 ALU, 2 store, 3 load, 4 store with read also set
  task automatic instr(input string nm, input int kind, input logic [2:0] c, input logic e,
                       input int fw, input int mw, input bit drop, input int lat);
    bit st = (kind == 2) || (kind == 4);
    bit ld = kind == 3;
    bit tk = taken(c, e);
    bit r;
    g_n = 0; g_seen = -1;
    n_rd = ld || kind == 4; n_wr = st; n_rw = (kind == 1) || ld; n_bc = c; n_eq = e;
    for (int i = 0; i <= fw; i++) begin
      n_rdy = (i == fw);
      cyc({nm, " fetch"}, ev(1, 0, 0, i == fw, 0, 0, 0, 1, 0));
      if (i == 0) g_start = s_count;
    end
    if (drop) n_run = 0;
    n_rdy = 1;
    cyc({nm, " decode"}, ev(0, 0, 0, 0, 0, 0, 0, 1, 0));
    r = kind == 0;
    cyc({nm, " exec"}, ev(0, 0, 0, 0, r, r & tk, 0, 1, 0));
    if (r) m_count = (m_count + 1) % 16;
    if (st || ld)
      for (int i = 0; i <= mw; i++) begin
        n_rdy = (i == mw);
        r = (i == mw) && st;
        cyc({nm, " mem"}, ev(1, st, 1, 0, r, r & tk, 0, 1, 0));
        if (r) m_count = (m_count + 1) % 16;
      end
    if (kind == 1 || ld) begin
      n_rdy = 0;
      cyc({nm, " wb"}, ev(0, 0, 0, 0, 1, tk, 1, 1, 0));
      m_count = (m_count + 1) % 16;
    end
    chk({nm, " latency"}, g_seen, lat);
  endtask

  initial begin
    n_rst = 0;
    repeat (2) cyc("reset", ev(0, 0, 0, 0, 0, 0, 0, 0, 0));
    n_rst = 1;
    cyc("idle run=0", ev(0, 0, 0, 0, 0, 0, 0, 0, 0));
    n_run = 1;
    cyc("idle run=1", ev(0, 0, 0, 0, 0, 0, 0, 0, 0));
    instr("alu", 1, 3'b010, 0, 0, 0, 0, 4);
    chk("alu pc_branch", g_br, 0);
    instr("load wait3", 3, 3'b010, 0, 0, 3, 0, 8);
    chk("count after alu", g_start, 1);
    instr("beq eq", 0, 3'b000, 1, 0, 0, 0, 3);
    chk("beq eq pc_branch", g_br, 1);
    instr("beq ne", 0, 3'b000, 0, 0, 0, 0, 3);
    chk("beq ne pc_branch", g_br, 0);
    instr("bne ne", 0, 3'b001, 0, 0, 0, 0, 3);
    chk("bne ne pc_branch", g_br, 1);
    instr("bne eq", 0, 3'b001, 1, 0, 0, 0, 3);
    instr("always", 0, 3'b011, 0, 0, 0, 0, 3);
    chk("always pc_branch", g_br, 1);
    instr("code100", 0, 3'b100, 1, 0, 0, 0, 3);
    chk("code100 pc_branch", g_br, 0);
    instr("alu fetch wait2", 1, 3'b010, 0, 2, 0, 0, 6);
    instr("load", 3, 3'b010, 0, 0, 0, 0, 5);
    instr("store rd+wr", 4, 3'b010, 0, 0, 0, 0, 4);
    instr("store run drop", 2, 3'b010, 0, 0, 0, 1, 4);
    repeat (3) cyc("stopped idle", ev(0, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("count after stop", s_count, 12);
    n_run = 1;
    cyc("restart idle", ev(0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (4) instr("nop", 0, 3'b010, 0, 0, 0, 0, 3);
    chk("count at 15", g_start, 15);
    instr("alu after wrap", 1, 3'b010, 0, 0, 0, 0, 4);
    chk("count wrapped", g_start, 0);
`ifndef SEQ_MEM_TIMEOUT_EN
    instr("long fetch", 1, 3'b010, 0, 20, 0, 0, 24);
    chk("no fault on long wait", s_count_fault, 0);
`endif
    n_rd = 1; n_wr = 0; n_rw = 1; n_bc = 3'b010; n_rdy = 1;
    cyc("rst fetch", ev(1, 0, 0, 1, 0, 0, 0, 1, 0));
    cyc("rst decode", ev(0, 0, 0, 0, 0, 0, 0, 1, 0));
    cyc("rst exec", ev(0, 0, 0, 0, 0, 0, 0, 1, 0));
    n_rdy = 0;
    cyc("rst mem wait", ev(1, 0, 1, 0, 0, 0, 0, 1, 0));
    n_rst = 0; m_count = 0;
    cyc("reset mid mem", ev(0, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("count after reset", s_count, 0);
    n_rst = 1; n_run = 0;
    cyc("after reset", ev(0, 0, 0, 0, 0, 0, 0, 0, 0));
`ifdef SEQ_MEM_TIMEOUT_EN
    n_run = 1;
    cyc("to idle run", ev(0, 0, 0, 0, 0, 0, 0, 0, 0));
    n_rdy = 0;
    repeat (15) cyc("timeout wait", ev(1, 0, 0, 0, 0, 0, 0, 1, 0));
    n_rdy = 1;
    for (int i = 0; i < 4; i++) begin
      n_run = i[0];
      cyc("fault held", ev(0, 0, 0, 0, 0, 0, 0, 1, 1));
    end
    chk("fault literal", s_count_fault, 1);
    n_rst = 0;
    cyc("fault reset", ev(0, 0, 0, 0, 0, 0, 0, 0, 0));
    n_rst = 1; n_run = 0;
    cyc("fault cleared", ev(0, 0, 0, 0, 0, 0, 0, 0, 0));
`endif
    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
